// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase controller.
package traffic_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_NS_GRN,
      ST_NS_YEL,
      ST_RED_A,
      ST_EW_GRN,
      ST_EW_YEL,
      ST_RED_B,
      ST_PED_WALK,
      ST_EMERG
   } state_t;

   typedef enum logic [1:0] {
      LT_RED = 2'b00,
      LT_YEL = 2'b01,
      LT_GRN = 2'b10
   } lamp_t;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_t;

   function automatic logic is_green(input state_t s);
      return (s == ST_NS_GRN) || (s == ST_EW_GRN);
   endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// Load/done handshake between the phase controller and the countdown timer.
interface traffic_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             timer_start;
   logic [WIDTH-1:0] timer_load;
   logic             timer_done;

   modport master (output timer_start, output timer_load, input timer_done);
   modport slave  (input timer_start, input timer_load, output timer_done);
endinterface

// File: rtl/ped_latch.sv
// Pedestrian request latch: set has priority over clear.
module ped_latch (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clr,
   output logic pend
);

   // A request arriving in the clearing cycle must not be lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pend <= 1'b0;
      else if (set)
         pend <= 1'b1;
      else if (clr)
         pend <= 1'b0;
   end

endmodule

// File: rtl/traffic_sequencer.sv
// Phase controller for a two-road intersection with pedestrian and emergency handling.
module traffic_sequencer
   import traffic_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned GRN_T   = 20,
   parameter int unsigned YEL_T   = 4,
   parameter int unsigned RED_T   = 2,
   parameter int unsigned WALK_T  = 8,
   parameter int unsigned MAX_EXT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ns_car,
   input  logic                ew_car,
   input  logic                ped_req,
   input  logic                emerg,
   traffic_sequencer_if.master tmr,
   output logic [1:0]          ns_light,
   output logic [1:0]          ew_light,
   output logic                walk,
   output logic                ped_ack
);

   localparam int unsigned EXT_W = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

   state_t             state_q, state_d;
   logic [EXT_W-1:0]   ext_q, ext_d;
   dir_t               dir_q, dir_d;
   logic               start_q, start_d;
   logic [WIDTH-1:0]   load_q, load_d;
   lamp_t              ns_d, ew_d;
   logic               walk_d, ack_d;
   logic               enter;
   logic               phase_done;
   logic               ped_pend;
   logic               ped_clr;

   function automatic logic [WIDTH-1:0] phase_load(input state_t s);
      case (s)
         ST_NS_GRN, ST_EW_GRN: phase_load = WIDTH'(GRN_T);
         ST_NS_YEL, ST_EW_YEL: phase_load = WIDTH'(YEL_T);
         ST_RED_A,  ST_RED_B:  phase_load = WIDTH'(RED_T);
         ST_PED_WALK:          phase_load = WIDTH'(WALK_T);
         default:              phase_load = '0;
      endcase
   endfunction

   ped_latch u_ped_latch (
      .clk   (clk),
      .reset (reset),
      .set   (ped_req),
      .clr   (ped_clr),
      .pend  (ped_pend)
   );

   assign tmr.timer_start = start_q;
   assign tmr.timer_load  = load_q;

   // done is stale while the load strobe is still out
   assign phase_done = tmr.timer_done && !start_q;

   // Next phase, timer loads and lamp values; emergency is checked before expiry.
   always_comb begin
      state_d = state_q;
      ext_d   = ext_q;
      dir_d   = dir_q;
      enter   = 1'b0;
      ack_d   = 1'b0;
      ped_clr = 1'b0;
      start_d = 1'b0;
      load_d  = load_q;
      ns_d    = LT_RED;
      ew_d    = LT_RED;
      walk_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_RED_B;
            enter   = 1'b1;
         end
         ST_NS_GRN, ST_EW_GRN: begin
            if (emerg) begin
               state_d = (state_q == ST_NS_GRN) ? ST_NS_YEL : ST_EW_YEL;
               enter   = 1'b1;
               ext_d   = '0;
            end else if (phase_done) begin
               enter = 1'b1;
               if (!((state_q == ST_NS_GRN) ? ew_car : ns_car) &&
                   (ext_q < EXT_W'(MAX_EXT))) begin
                  ext_d = ext_q + 1'b1;
               end else begin
                  state_d = (state_q == ST_NS_GRN) ? ST_NS_YEL : ST_EW_YEL;
                  ext_d   = '0;
               end
            end
         end
         ST_NS_YEL, ST_EW_YEL: begin
            if (phase_done) begin
               if (emerg) begin
                  state_d = ST_EMERG;
               end else begin
                  state_d = (state_q == ST_NS_YEL) ? ST_RED_A : ST_RED_B;
                  enter   = 1'b1;
               end
            end
         end
         ST_RED_A, ST_RED_B: begin
            if (phase_done) begin
               if (emerg) begin
                  state_d = ST_EMERG;
               end else if (ped_pend) begin
                  state_d = ST_PED_WALK;
                  dir_d   = (state_q == ST_RED_A) ? DIR_EW : DIR_NS;
                  enter   = 1'b1;
                  ack_d   = 1'b1;
                  ped_clr = 1'b1;
               end else begin
                  state_d = (state_q == ST_RED_A) ? ST_EW_GRN : ST_NS_GRN;
                  enter   = 1'b1;
               end
            end
         end
         ST_PED_WALK: begin
            if (emerg) begin
               state_d = ST_EMERG;
            end else if (phase_done) begin
               state_d = (dir_q == DIR_EW) ? ST_EW_GRN : ST_NS_GRN;
               enter   = 1'b1;
            end
         end
         ST_EMERG: begin
            if (!emerg) begin
               state_d = ST_RED_B;
               enter   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (enter) begin
         start_d = 1'b1;
         load_d  = phase_load(state_d);
      end

      case (state_d)
         ST_NS_GRN:   ns_d   = LT_GRN;
         ST_NS_YEL:   ns_d   = LT_YEL;
         ST_EW_GRN:   ew_d   = LT_GRN;
         ST_EW_YEL:   ew_d   = LT_YEL;
         ST_PED_WALK: walk_d = 1'b1;
         default:     ;
      endcase
   end

   // State and registered outputs; every output follows the state it is entering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ext_q    <= '0;
         dir_q    <= DIR_NS;
         start_q  <= 1'b0;
         load_q   <= '0;
         ns_light <= LT_RED;
         ew_light <= LT_RED;
         walk     <= 1'b0;
         ped_ack  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ext_q    <= ext_d;
         dir_q    <= dir_d;
         start_q  <= start_d;
         load_q   <= load_d;
         ns_light <= ns_d;
         ew_light <= ew_d;
         walk     <= walk_d;
         ped_ack  <= ack_d;
      end
   end

endmodule
